execute_cycle: RTL
==================

# execute_cycle

Execute stage of the five-stage RV32I pipeline: consumes the ID/EX register outputs of the decode stage, performs operand forwarding, the ALU operation and branch resolution, and registers the results into the EX/MEM pipeline register for the memory stage. It also drives the branch-taken redirect (PCSrc_E, PCTarget_E) back to fetch.

## Interface
- No parameters; datapath width fixed at 32, register index width 5.
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E, ALUSrc_E  input  1 each  control from ID/EX register
- ALUControl_E  input  3  ALU operation select
- RD1_E, RD2_E  input  32  register-file read data
- Imm_Ext_E  input  32  sign-extended immediate
- Mux1_E  input  32  decode-side SrcB (RD2 or immediate, pre-selected)
- PC_E, PCPlus4_E  input  32  instruction PC and PC+4
- Rd_E  input  5  destination register index
- ForwardA_E, ForwardB_E  input  2  forwarding selects from hazard unit
- ALUResult_M_fwd, Result_W  input  32  forwarded values from MEM and WB
- Stall_M  input  1  hold EX/MEM register
- Flush_M  input  1  insert bubble into EX/MEM register
- PCSrc_E  output  1  branch taken, redirect fetch
- PCTarget_E  output  32  PC_E + Imm_Ext_E
- RegWrite_M, MemWrite_M, ResultSrc_M  output  1 each  registered control
- ALUResult_M, WriteData_M, PCPlus4_M  output  32  registered datapath
- Rd_M  output  5  registered destination index
- Zero_M  output  1  registered ALU zero flag

## Operation
- Operand A: ForwardA_E 00 -> RD1_E, 01 -> Result_W, 10 -> ALUResult_M_fwd, 11 -> RD1_E.
- Forwarded B (FwdB): same encoding applied to RD2_E. SrcB = ALUSrc_E ? Imm_Ext_E : FwdB.
- ALUControl_E: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 0 or 1), 110 sltu, 100 xor; 111 -> result 0.
- Add/sub wrap modulo 2^32, no overflow trap. Zero = (ALU result == 0).
- PCSrc_E = Branch_E & Zero (beq semantics); PCTarget_E = PC_E + Imm_Ext_E, modulo 2^32.
- WriteData_M captures FwdB (store data never takes the immediate).
- Register update priority per rising edge: rst > Flush_M > Stall_M > normal load.
- Flush_M: RegWrite_M, MemWrite_M, ResultSrc_M, Zero_M <= 0; Rd_M <= 0; datapath outputs <= 0.
- Stall_M (no flush): all EX/MEM outputs hold.
- Branch-taken instruction itself is not flushed here; squashing younger instructions is the hazard unit's job using PCSrc_E.

## Timing
- E-side inputs to _M outputs: 1 cycle latency.
- PCSrc_E, PCTarget_E: combinational from current E inputs, same cycle; PCSrc_E forced 0 while rst is high.
- Reset: every registered output 0 on the first rising edge with rst high; remains 0 while rst held; first valid load on the first edge after rst deasserts.
- Reset asserted mid-stall or mid-flush: reset wins, outputs 0 next edge.
- Stall_M and Flush_M both high: flush wins.
- Stall released: next edge loads the then-current E inputs (held instruction is overwritten; upstream is responsible for holding E inputs).

## Configuration
- Macro EXEC_FORWARDING_EN.
- Defined: forwarding muxes as above; SrcB built locally from FwdB/Imm_Ext_E; Mux1_E unused.
- Undefined: ForwardA_E/ForwardB_E, ALUResult_M_fwd, Result_W ignored; SrcA = RD1_E, SrcB = Mux1_E, WriteData_M = RD2_E. Port list unchanged.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all _M outputs 0, PCSrc_E=0; first edge after release loads inputs.
- ALU: RD1_E=0x7FFFFFFF, SrcB imm 1, add -> ALUResult_M=0x80000000 after 1 cycle; RD1=0xFFFFFFFF, RD2=1, slt -> 1, sltu -> 0.
- Branch: Branch_E=1, RD1=RD2=5, sub, PC_E=0x100, Imm=0xFFFFFFF0 -> PCSrc_E=1, PCTarget_E=0x000000F0 same cycle, Zero_M=1 next cycle.
- Forwarding (macro on): ForwardA=10, ALUResult_M_fwd=0x10, ForwardB=01, Result_W=0x3, ALUSrc=0, sub -> ALUResult_M=0xD, WriteData_M=0x3; macro off same stimulus -> uses RD1_E/Mux1_E.
- Stall then flush: load RegWrite=1 Rd=7, then Stall_M=1 with new inputs -> outputs hold Rd_M=7; then Stall_M=1, Flush_M=1 -> RegWrite_M=0, Rd_M=0.
- Store data: MemWrite_E=1, ALUSrc=1, Imm=8, RD1=0x1000, RD2=0xABCD -> ALUResult_M=0x1008, WriteData_M=0xABCD, MemWrite_M=1.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Define EXEC_FORWARDING_EN to build the local forwarding muxes; otherwise pre-selected decode operands are used.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_E,
    input  logic        MemWrite_E,
    input  logic        ResultSrc_E,
    input  logic        Branch_E,
    input  logic        ALUSrc_E,
    input  logic [2:0]  ALUControl_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] Mux1_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] PCPlus4_E,
    input  logic [4:0]  Rd_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ALUResult_M_fwd,
    input  logic [31:0] Result_W,
    input  logic        Stall_M,
    input  logic        Flush_M,
    output logic        PCSrc_E,
    output logic [31:0] PCTarget_E,
    output logic        RegWrite_M,
    output logic        MemWrite_M,
    output logic        ResultSrc_M,
    output logic [31:0] ALUResult_M,
    output logic [31:0] WriteData_M,
    output logic [31:0] PCPlus4_M,
    output logic [4:0]  Rd_M,
    output logic        Zero_M
);

    logic [31:0] src_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] src_b_s;
    logic [31:0] alu_result_s;
    logic        zero_s;
    logic        cfg_unused_s;

    function automatic logic [31:0] alu_calc(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Encoding 11 is reserved and falls back to the register-file value.
    function automatic logic [31:0] fwd_sel(
        input logic [1:0]  sel,
        input logic [31:0] rf_val,
        input logic [31:0] wb_val,
        input logic [31:0] mem_val
    );
        logic [31:0] r;
        case (sel)
            2'b01:   r = wb_val;
            2'b10:   r = mem_val;
            default: r = rf_val;
        endcase
        return r;
    endfunction

`ifdef EXEC_FORWARDING_EN
    assign src_a_s      = fwd_sel(ForwardA_E, RD1_E, Result_W, ALUResult_M_fwd);
    assign fwd_b_s      = fwd_sel(ForwardB_E, RD2_E, Result_W, ALUResult_M_fwd);
    assign src_b_s      = ALUSrc_E ? Imm_Ext_E : fwd_b_s;
    assign cfg_unused_s = ^Mux1_E;
`else
    assign src_a_s      = RD1_E;
    assign fwd_b_s      = RD2_E;
    assign src_b_s      = Mux1_E;
    assign cfg_unused_s = ^{ForwardA_E, ForwardB_E, ALUResult_M_fwd, Result_W, ALUSrc_E};
`endif

    assign alu_result_s = alu_calc(ALUControl_E, src_a_s, src_b_s);
    assign zero_s       = (alu_result_s == 32'd0);

    // Redirect is suppressed during reset so fetch never follows garbage operands.
    assign PCSrc_E    = rst ? 1'b0 : (Branch_E & zero_s);
    assign PCTarget_E = PC_E + Imm_Ext_E;

    // EX/MEM register: reset beats flush, flush beats stall.
    always_ff @(posedge clk) begin
        if (rst || Flush_M) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            ALUResult_M <= 32'd0;
            WriteData_M <= 32'd0;
            PCPlus4_M   <= 32'd0;
            Rd_M        <= 5'd0;
            Zero_M      <= 1'b0;
        end else if (!Stall_M) begin
            RegWrite_M  <= RegWrite_E;
            MemWrite_M  <= MemWrite_E;
            ResultSrc_M <= ResultSrc_E;
            ALUResult_M <= alu_result_s;
            WriteData_M <= fwd_b_s;
            PCPlus4_M   <= PCPlus4_E;
            Rd_M        <= Rd_E;
            Zero_M      <= zero_s;
        end else begin
            RegWrite_M  <= RegWrite_M;
            MemWrite_M  <= MemWrite_M;
            ResultSrc_M <= ResultSrc_M;
            ALUResult_M <= ALUResult_M;
            WriteData_M <= WriteData_M;
            PCPlus4_M   <= PCPlus4_M;
            Rd_M        <= Rd_M;
            Zero_M      <= Zero_M;
        end
    end

endmodule
